// File: rtl/comparador22_pkg.sv
// Shared constants for the 22-member set detector.
//   MATCH_SET   : bit i set iff i is a member of the set
//   MATCH_COUNT : number of members
//   gate_match(): AND/OR/NOT equation for the same set
package comparador22_pkg;

    localparam int unsigned NUM_W       = 6;
    localparam int unsigned MATCH_COUNT = 22;

    // Members: 0 3 5 6 9 10 12 15 17 18 20 23 24 27 29 30 33 34 36 39 40 43
    localparam logic [63:0] MATCH_SET = 64'h0000_0996_6996_9669;

    // The set is exactly the even-parity values below 44. Parity is built as
    // a factored sum-of-products of bit pairs; the bound 44 (6'b101100) is
    // !n5 | (!n4 & !(n3 & n2)).
    function automatic logic gate_match(input logic [NUM_W-1:0] n);
        logic x10;
        logic x32;
        logic x54;
        logic x_lo;
        logic odd;
        logic below_44;
        x10      = (n[1] & ~n[0]) | (~n[1] & n[0]);
        x32      = (n[3] & ~n[2]) | (~n[3] & n[2]);
        x54      = (n[5] & ~n[4]) | (~n[5] & n[4]);
        x_lo     = (x10 & ~x32) | (~x10 & x32);
        odd      = (x_lo & ~x54) | (~x_lo & x54);
        below_44 = ~n[5] | (~n[4] & ~(n[3] & n[2]));
        return ~odd & below_44;
    endfunction

endpackage

// File: rtl/comparador22_decodificador3a8.sv
// decodificador3a8: 3-to-8 one-hot decoder, combinational.
//   a : 3-bit select
//   y : one-hot output, y[a] = 1
module decodificador3a8 (
    input  logic [2:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h01 << a;
    end

endmodule

// File: rtl/comparador22_multiplexor4a1.sv
// multiplexor4a1: 4:1 single-bit multiplexer, combinational.
//   sel : 2-bit select
//   d   : data inputs
//   y   : d[sel]
module multiplexor4a1 (
    input  logic [1:0] sel,
    input  logic [3:0] d,
    output logic       y
);

    always_comb begin
        y = d[sel];
    end

endmodule

// File: rtl/comparador22_numeros6bit.sv
// comparador22_numeros6bit: registered 6-bit set-membership detector.
// Membership is computed by three independent paths (gates, decoders, mux
// tree); each result, their majority and a disagreement flag are registered.
//   clk                 : clock, rising edge
//   reset               : asynchronous active-high clear of all outputs
//   numero              : value under test
//   match_compuertas    : gate-path result
//   match_decodificador : decoder-path result
//   match_multiplexor   : mux-tree result
//   match               : majority of the three
//   mismatch            : paths disagree
module comparador22_numeros6bit
    import comparador22_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] numero,
    output logic       match_compuertas,
    output logic       match_decodificador,
    output logic       match_multiplexor,
    output logic       match,
    output logic       mismatch
);

    // ---------------- gate path ----------------
    logic gate_y;
    assign gate_y = gate_match(numero);

    // ---------------- decoder path ----------------
    logic [7:0]  dec_hi;
    logic [7:0]  dec_lo;
    logic [63:0] minterm;
    logic        dec_y;

    decodificador3a8 u_dec_hi (
        .a (numero[5:3]),
        .y (dec_hi)
    );

    decodificador3a8 u_dec_lo (
        .a (numero[2:0]),
        .y (dec_lo)
    );

    always_comb begin
        for (int i = 0; i < 64; i++) begin
            minterm[i] = dec_hi[i / 8] & dec_lo[i % 8];
        end
        dec_y = |(minterm & MATCH_SET);
    end

    // ---------------- mux-tree path ----------------
    // Kept as a named net so the data bits can be probed individually.
    logic [63:0] mux_data;
    logic [15:0] mux_l1;
    logic [3:0]  mux_l2;
    logic        mux_y;

    assign mux_data = MATCH_SET;

    for (genvar g = 0; g < 16; g++) begin : g_mux_l1
        multiplexor4a1 u_mux (
            .sel (numero[1:0]),
            .d   (mux_data[4*g +: 4]),
            .y   (mux_l1[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_mux_l2
        multiplexor4a1 u_mux (
            .sel (numero[3:2]),
            .d   (mux_l1[4*g +: 4]),
            .y   (mux_l2[g])
        );
    end

    multiplexor4a1 u_mux_l3 (
        .sel (numero[5:4]),
        .d   (mux_l2),
        .y   (mux_y)
    );

    // ---------------- vote and register ----------------
    logic match_compuertas_d, match_compuertas_q;
    logic match_decodificador_d, match_decodificador_q;
    logic match_multiplexor_d, match_multiplexor_q;
    logic match_d, match_q;
    logic mismatch_d, mismatch_q;

    always_comb begin
        match_compuertas_d    = gate_y;
        match_decodificador_d = dec_y;
        match_multiplexor_d   = mux_y;
        match_d    = (gate_y & dec_y) | (gate_y & mux_y) | (dec_y & mux_y);
        mismatch_d = ~((gate_y == dec_y) && (dec_y == mux_y));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_compuertas_q    <= 1'b0;
            match_decodificador_q <= 1'b0;
            match_multiplexor_q   <= 1'b0;
            match_q               <= 1'b0;
            mismatch_q            <= 1'b0;
        end else begin
            match_compuertas_q    <= match_compuertas_d;
            match_decodificador_q <= match_decodificador_d;
            match_multiplexor_q   <= match_multiplexor_d;
            match_q               <= match_d;
            mismatch_q            <= mismatch_d;
        end
    end

    assign match_compuertas    = match_compuertas_q;
    assign match_decodificador = match_decodificador_q;
    assign match_multiplexor   = match_multiplexor_q;
    assign match               = match_q;
    assign mismatch            = mismatch_q;

endmodule

// File: tb/tb_comparador22_numeros6bit.sv
// Self-checking bench for comparador22_numeros6bit and its sub-modules.
module tb_comparador22_numeros6bit;

    logic       clk;
    logic       reset;
    logic [5:0] numero;
    logic       match_compuertas;
    logic       match_decodificador;
    logic       match_multiplexor;
    logic       match;
    logic       mismatch;

    logic [2:0] dec_a;
    logic [7:0] dec_y;
    logic [1:0] mux_sel;
    logic [3:0] mux_d;
    logic       mux_y;

    int n_total;
    int n_bad;

    // Hand-listed members of the set.
    int s_list [22] = '{0, 3, 5, 6, 9, 10, 12, 15, 17, 18, 20, 23, 24, 27, 29, 30,
                        33, 34, 36, 39, 40, 43};

    comparador22_numeros6bit dut (
        .clk                 (clk),
        .reset               (reset),
        .numero              (numero),
        .match_compuertas    (match_compuertas),
        .match_decodificador (match_decodificador),
        .match_multiplexor   (match_multiplexor),
        .match               (match),
        .mismatch            (mismatch)
    );

    decodificador3a8 u_dec (
        .a (dec_a),
        .y (dec_y)
    );

    multiplexor4a1 u_mux (
        .sel (mux_sel),
        .d   (mux_d),
        .y   (mux_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_member(input int v);
        for (int i = 0; i < 22; i++) begin
            if (s_list[i] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_all"}, {27'd0, match_compuertas, match_decodificador,
                                 match_multiplexor, match, mismatch}, 32'd0);
    endtask

    // Drive a value, let one rising edge sample it, then settle just after.
    task automatic apply(input logic [5:0] v);
        numero = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string tag, input logic exp);
        check_eq({tag, "_match"}, {31'd0, match}, {31'd0, exp});
        check_eq({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
        check_eq({tag, "_gate"}, {31'd0, match_compuertas}, {31'd0, exp});
        check_eq({tag, "_dec"}, {31'd0, match_decodificador}, {31'd0, exp});
        check_eq({tag, "_mux"}, {31'd0, match_multiplexor}, {31'd0, exp});
    endtask

    initial begin
        int hits;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        numero  = 6'd0;
        dec_a   = 3'd0;
        mux_sel = 2'd0;
        mux_d   = 4'b1010;

        // Reset state, before any clock edge and after a few.
        #1;
        check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        reset = 1'b0;

        // Full sweep.
        hits = 0;
        for (int v = 0; v < 64; v++) begin
            apply(v[5:0]);
            check_value($sformatf("sweep%0d", v), is_member(v));
            if (match) hits++;
        end
        check_eq("sweep_hits", hits, 22);

        // Spot values.
        apply(6'd0);  check_eq("spot0",  {31'd0, match}, 32'd1);
        apply(6'd3);  check_eq("spot3",  {31'd0, match}, 32'd1);
        apply(6'd4);  check_eq("spot4",  {31'd0, match}, 32'd0);
        apply(6'd43); check_eq("spot43", {31'd0, match}, 32'd1);
        apply(6'd44); check_eq("spot44", {31'd0, match}, 32'd0);
        apply(6'd63); check_eq("spot63", {31'd0, match}, 32'd0);

        // Mid-sweep asynchronous reset with no clock edge in between.
        apply(6'd12);
        check_eq("pre_reset12", {31'd0, match}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        numero = 6'd15;
        @(posedge clk);
        #1;
        check_all_zero("midreset_edge");
        reset = 1'b0;
        apply(6'd15);
        check_value("after_reset15", 1'b1);

        // Fault in the mux-path data: majority still votes 1, disagreement flagged.
        force dut.mux_data = 64'h0000_0996_6996_9669 & ~(64'd1 << 5);
        apply(6'd5);
        check_eq("fault_mismatch", {31'd0, mismatch}, 32'd1);
        check_eq("fault_match", {31'd0, match}, 32'd1);
        check_eq("fault_mux", {31'd0, match_multiplexor}, 32'd0);
        release dut.mux_data;
        apply(6'd5);
        check_value("fault_released5", 1'b1);

        // Decoder standalone.
        for (int i = 0; i < 8; i++) begin
            dec_a = i[2:0];
            #1;
            check_eq($sformatf("dec%0d", i), {24'd0, dec_y}, 32'd1 << i);
            check_eq($sformatf("dec%0d_ones", i), $countones(dec_y), 32'd1);
        end

        // Mux standalone with d = 1010.
        for (int i = 0; i < 4; i++) begin
            mux_sel = i[1:0];
            #1;
            check_eq($sformatf("mux_sel%0d", i), {31'd0, mux_y}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
